// File: rtl/result_collector.sv
// Result collector: round-robin grant over engine service requests, two-cycle req_ack
// handshake, capture of the shared result bus, frame-buffer write with backpressure,
// and per-frame pixel counting.
module result_collector #(
  parameter int unsigned N_ENGINES = 8,
  parameter int unsigned H_RES     = 640,
  parameter int unsigned V_RES     = 480
) (
  input  logic                 Engine_CLK,
  input  logic                 eRST,
  input  logic [N_ENGINES-1:0] service_req,
  input  logic [26:0]          result_bus,
  output logic [N_ENGINES-1:0] req_ack,
  input  logic                 fb_ready,
  output logic                 fb_we,
  output logic [18:0]          fb_addr,
  output logic [7:0]           fb_data,
  input  logic                 frame_clear,
  output logic [18:0]          pixels_done,
  output logic                 frame_done,
  output logic                 coord_err
);

  localparam int unsigned IdxW        = (N_ENGINES > 1) ? $clog2(N_ENGINES) : 1;
  localparam logic [18:0] FramePixels = 19'(H_RES * V_RES);

  typedef enum logic [2:0] {StIdle, StAck1, StAck2, StWrite, StRelease} state_e;

  state_e                 state_q, state_d;
  // last_q is both the round-robin pointer and the engine currently being served.
  logic [IdxW-1:0]        last_q, last_d;
  logic [N_ENGINES-1:0]   ack_q, ack_d;
  logic                   we_q, we_d;
  logic [18:0]            addr_q, addr_d;
  logic [7:0]             data_q, data_d;
  logic [18:0]            pix_q, pix_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   any_req;
  logic [IdxW-1:0]        winner;
  logic                   err_set;
  logic                   pix_inc;

  logic [9:0]             bus_x;
  logic [8:0]             bus_y;
  logic [7:0]             bus_iter;
  logic [18:0]            addr_calc;
  logic                   coord_ok;

  assign bus_x     = result_bus[26:17];
  assign bus_y     = result_bus[16:8];
  assign bus_iter  = result_bus[7:0];
  assign addr_calc = 19'(bus_y) * 19'(H_RES) + 19'(bus_x);
  assign coord_ok  = (32'(bus_x) < H_RES) && (32'(bus_y) < V_RES);

  // Round-robin search starting just above the last winner, wrapping around.
  always_comb begin
    int unsigned idx;
    any_req = 1'b0;
    winner  = last_q;
    idx     = 0;
    for (int unsigned k = 1; k <= N_ENGINES; k++) begin
      idx = (32'(last_q) + k) % N_ENGINES;
      if (!any_req && service_req[IdxW'(idx)]) begin
        any_req = 1'b1;
        winner  = IdxW'(idx);
      end
    end
  end

  // Handshake / write state machine next-state logic.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    ack_d   = ack_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_set = 1'b0;
    pix_inc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          ack_d         = '0;
          ack_d[winner] = 1'b1;
          last_d        = winner;
          state_d       = StAck1;
        end
      end
      // Extra cycle so the bus settles and the engine observes the ack.
      StAck1: state_d = StAck2;
      StAck2: begin
        ack_d  = '0;
        addr_d = addr_calc;
        data_d = bus_iter;
        if (coord_ok) begin
          we_d    = 1'b1;
          state_d = StWrite;
        end else begin
          err_set = 1'b1;
          state_d = StRelease;
        end
      end
      StWrite: begin
        if (fb_ready) begin
          we_d    = 1'b0;
          pix_inc = 1'b1;
          state_d = StRelease;
        end
      end
      // Wait for the served engine to drop its request so it is not granted twice.
      StRelease: begin
        if (!service_req[last_q]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Pixel count, frame-complete pulse and sticky coordinate error.
  always_comb begin
    pix_d  = pix_q;
    done_d = 1'b0;
    err_d  = err_q;
    if (frame_clear) begin
      pix_d = '0;
      err_d = 1'b0;
    end else if (pix_inc) begin
      if (pix_q + 19'd1 == FramePixels) begin
        pix_d  = '0;
        done_d = 1'b1;
      end else begin
        pix_d = pix_q + 19'd1;
      end
    end
    if (err_set) err_d = 1'b1;
  end

  // State registers; reset drops any handshake or write in flight.
  always_ff @(posedge Engine_CLK or posedge eRST) begin
    if (eRST) begin
      state_q <= StIdle;
      last_q  <= IdxW'(N_ENGINES - 1);
      ack_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      pix_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      pix_q   <= pix_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign req_ack     = ack_q;
  assign fb_we       = we_q;
  assign fb_addr     = addr_q;
  assign fb_data     = data_q;
  assign pixels_done = pix_q;
  assign frame_done  = done_q;
  assign coord_err   = err_q;

endmodule

// File: tb/tb_result_collector.sv
// Self-checking bench for result_collector: a 640x480 instance with 8 engines and a
// 4x2 instance with 2 engines for the frame-wrap scenarios.
module tb_result_collector;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  service_req;
  logic [26:0]   bus;
  logic [N-1:0]  req_ack;
  logic          fb_ready;
  logic          fb_we;
  logic [18:0]   fb_addr;
  logic [7:0]    fb_data;
  logic          frame_clear;
  logic [18:0]   pixels_done;
  logic          frame_done;
  logic          coord_err;

  logic [1:0]    sreq2;
  logic [26:0]   bus2;
  logic [1:0]    ack2;
  logic          ready2;
  logic          we2;
  logic [18:0]   addr2;
  logic [7:0]    data2;
  logic          clear2;
  logic [18:0]   pix2;
  logic          done2;
  logic          err2;

  always #5 clk = ~clk;

  result_collector #(.N_ENGINES(N), .H_RES(640), .V_RES(480)) dut (
    .Engine_CLK(clk), .eRST(rst), .service_req(service_req), .result_bus(bus),
    .req_ack(req_ack), .fb_ready(fb_ready), .fb_we(fb_we), .fb_addr(fb_addr),
    .fb_data(fb_data), .frame_clear(frame_clear), .pixels_done(pixels_done),
    .frame_done(frame_done), .coord_err(coord_err)
  );

  result_collector #(.N_ENGINES(2), .H_RES(4), .V_RES(2)) dut_small (
    .Engine_CLK(clk), .eRST(rst), .service_req(sreq2), .result_bus(bus2),
    .req_ack(ack2), .fb_ready(ready2), .fb_we(we2), .fb_addr(addr2),
    .fb_data(data2), .frame_clear(clear2), .pixels_done(pix2),
    .frame_done(done2), .coord_err(err2)
  );

  int          checks = 0;
  int          fails  = 0;
  int          exp_grant_q[$];
  logic [26:0] exp_wr_q[$];
  logic [26:0] eng_word[N];
  bit          eng_seen[N];
  logic [N-1:0] prev_ack;
  logic        prev_we;
  int          ack_len;
  int          we_len;
  int          writes_cnt;
  int          done_pulses;
  logic [26:0] held;

  // One cycle: sample at the falling edge, check the handshake, then play the engines.
  task automatic tick();
    int gidx;
    int eg;
    logic [26:0] ew;
    @(negedge clk);
    if (frame_done) done_pulses++;
    checks++;
    if ($countones(req_ack) > 1) begin
      fails++;
      $display("FAIL onehot: req_ack=%b, required at most one bit set", req_ack);
    end
    if (req_ack != '0) begin
      if (prev_ack == '0) begin
        gidx = 0;
        for (int i = 0; i < N; i++) if (req_ack[3'(i)]) gidx = i;
        checks++;
        if (exp_grant_q.size() == 0) begin
          fails++;
          $display("FAIL grant: unexpected grant to engine %0d, required none", gidx);
        end else begin
          eg = exp_grant_q.pop_front();
          if (gidx != eg) begin
            fails++;
            $display("FAIL grant: got engine %0d, required engine %0d", gidx, eg);
          end
        end
        ack_len = 1;
      end else begin
        ack_len++;
        checks++;
        if (req_ack !== prev_ack) begin
          fails++;
          $display("FAIL ack_hold: req_ack=%b, required %b", req_ack, prev_ack);
        end
      end
    end else if (prev_ack != '0) begin
      checks++;
      if (ack_len != 2) begin
        fails++;
        $display("FAIL ack_len: req_ack high %0d cycles, required 2", ack_len);
      end
    end
    if (fb_we && !prev_we) begin
      checks++;
      if (exp_wr_q.size() == 0) begin
        fails++;
        $display("FAIL write: unexpected write addr=%0d data=%h, required none", fb_addr, fb_data);
      end else begin
        ew = exp_wr_q.pop_front();
        if ({fb_addr, fb_data} !== ew) begin
          fails++;
          $display("FAIL write: addr=%0d data=%h, required addr=%0d data=%h",
                   fb_addr, fb_data, ew[26:8], ew[7:0]);
        end
      end
      held   = {fb_addr, fb_data};
      we_len = 1;
    end else if (fb_we) begin
      we_len++;
      checks++;
      if ({fb_addr, fb_data} !== held) begin
        fails++;
        $display("FAIL write_stable: addr=%0d data=%h, required addr=%0d data=%h",
                 fb_addr, fb_data, held[26:8], held[7:0]);
      end
    end
    if (prev_we && !fb_we) writes_cnt++;
    prev_ack = req_ack;
    prev_we  = fb_we;
    bus = 27'h5a5a5a5;
    for (int i = 0; i < N; i++) begin
      if (req_ack[3'(i)]) begin
        bus         = eng_word[i];
        eng_seen[i] = 1'b1;
      end else if (eng_seen[i]) begin
        service_req[3'(i)] = 1'b0;
        eng_seen[i]        = 1'b0;
      end
    end
  endtask

  task automatic post_req(input int e, input int x, input int y, input int it, input bit valid);
    eng_word[e] = {10'(x), 9'(y), 8'(it)};
    service_req[3'(e)] = 1'b1;
    exp_grant_q.push_back(e);
    if (valid) exp_wr_q.push_back({19'(y * 640 + x), 8'(it)});
  endtask

  task automatic wait_writes(input int target, input int budget, input string name);
    int k;
    for (k = 0; k < budget && writes_cnt < target; k++) tick();
    checks++;
    if (writes_cnt < target) begin
      fails++;
      $display("FAIL %s_timeout: %0d writes seen, required %0d", name, writes_cnt, target);
    end
    repeat (3) tick();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    service_req = '0;
    for (int i = 0; i < N; i++) eng_seen[i] = 1'b0;
    exp_grant_q.delete();
    exp_wr_q.delete();
    prev_ack = '0;
    prev_we  = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if (req_ack !== '0 || fb_we !== 1'b0) begin
      fails++;
      $display("FAIL reset_hs: req_ack=%b fb_we=%b, required 0 0", req_ack, fb_we);
    end
    checks++;
    if (fb_addr !== '0 || fb_data !== '0) begin
      fails++;
      $display("FAIL reset_fb: addr=%0d data=%h, required 0 0", fb_addr, fb_data);
    end
    checks++;
    if (pixels_done !== '0 || frame_done !== 1'b0 || coord_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_cnt: pix=%0d done=%b err=%b, required 0 0 0",
               pixels_done, frame_done, coord_err);
    end
    rst = 1'b0;
    repeat (2) tick();
    checks++;
    if (req_ack !== '0 || pix2 !== '0) begin
      fails++;
      $display("FAIL idle_after_reset: req_ack=%b pix2=%0d, required 0 0", req_ack, pix2);
    end
  endtask

  task automatic test_single();
    fb_ready = 1'b1;
    post_req(0, 3, 2, 8'h2a, 1'b1);
    wait_writes(1, 20, "single");
    checks++;
    if (we_len != 1) begin
      fails++;
      $display("FAIL single_we_len: fb_we high %0d cycles, required 1", we_len);
    end
    checks++;
    if (exp_wr_q.size() != 0 || fb_addr !== 19'd1283 || fb_data !== 8'h2a) begin
      fails++;
      $display("FAIL single_write: addr=%0d data=%h, required 1283 2a", fb_addr, fb_data);
    end
    checks++;
    if (pixels_done !== 19'd1) begin
      fails++;
      $display("FAIL single_pix: pixels_done=%0d, required 1", pixels_done);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    fb_ready = 1'b1;
    post_req(0, 10, 0, 1, 1'b1);
    post_req(3, 20, 1, 2, 1'b1);
    post_req(5, 639, 479, 3, 1'b1);
    wait_writes(writes_cnt + 3, 60, "rr");
    checks++;
    if (exp_grant_q.size() != 0 || exp_wr_q.size() != 0) begin
      fails++;
      $display("FAIL rr_drain: %0d grants %0d writes left, required 0 0",
               exp_grant_q.size(), exp_wr_q.size());
    end
    checks++;
    if (pixels_done !== 19'd3) begin
      fails++;
      $display("FAIL rr_pix: pixels_done=%0d, required 3", pixels_done);
    end
  endtask

  task automatic test_backpressure();
    int base;
    int k;
    fb_ready = 1'b0;
    post_req(1, 5, 5, 8'h11, 1'b1);
    for (k = 0; k < 10 && !fb_we; k++) tick();
    post_req(2, 6, 6, 8'h22, 1'b1);
    base = writes_cnt;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (fb_we !== 1'b1 || req_ack !== '0) begin
        fails++;
        $display("FAIL bp_stall: fb_we=%b req_ack=%b, required 1 0", fb_we, req_ack);
      end
    end
    fb_ready = 1'b1;
    tick();
    checks++;
    if (fb_we !== 1'b0 || writes_cnt != base + 1) begin
      fails++;
      $display("FAIL bp_release: fb_we=%b writes=%0d, required 0 %0d", fb_we, writes_cnt, base + 1);
    end
    wait_writes(base + 2, 30, "bp");
    checks++;
    if (pixels_done !== 19'd5) begin
      fails++;
      $display("FAIL bp_pix: pixels_done=%0d, required 5", pixels_done);
    end
  endtask

  task automatic test_coord_err();
    int base;
    base = writes_cnt;
    post_req(4, 700, 10, 8'h33, 1'b0);
    repeat (12) tick();
    checks++;
    if (writes_cnt != base || coord_err !== 1'b1 || pixels_done !== 19'd5) begin
      fails++;
      $display("FAIL coord_err: writes=%0d err=%b pix=%0d, required %0d 1 5",
               writes_cnt, coord_err, pixels_done, base);
    end
    checks++;
    if (exp_grant_q.size() != 0 || service_req[4] !== 1'b0) begin
      fails++;
      $display("FAIL coord_grant: %0d grants left req4=%b, required 0 0",
               exp_grant_q.size(), service_req[4]);
    end
    post_req(6, 1, 1, 8'h44, 1'b1);
    wait_writes(base + 1, 20, "coord_next");
    checks++;
    if (coord_err !== 1'b1 || pixels_done !== 19'd6) begin
      fails++;
      $display("FAIL coord_sticky: err=%b pix=%0d, required 1 6", coord_err, pixels_done);
    end
  endtask

  // One write on the 4x2 instance; clr asserts frame_clear on the increment edge.
  task automatic small_write(input int p, input bit clr);
    bit seen;
    int wes;
    seen  = 1'b0;
    wes   = 0;
    sreq2 = 2'b01;
    bus2  = {10'(p % 4), 9'(p / 4), 8'(p + 8'h40)};
    for (int i = 0; i < 7; i++) begin
      tick();
      if (done2) done_pulses++;
      if (ack2[0]) seen = 1'b1;
      else if (seen) sreq2 = 2'b00;
      if (we2) begin
        wes++;
        checks++;
        if (addr2 !== 19'(p) || data2 !== 8'(p + 8'h40)) begin
          fails++;
          $display("FAIL small_write: addr=%0d data=%h, required %0d %h", addr2, data2, p, p + 8'h40);
        end
        clear2 = clr;
      end else begin
        clear2 = 1'b0;
      end
    end
    sreq2 = 2'b00;
    checks++;
    if (wes != 1) begin
      fails++;
      $display("FAIL small_we: %0d write cycles, required 1", wes);
    end
  endtask

  task automatic test_frame();
    ready2 = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      done_pulses = 0;
      for (int p = 0; p < 7; p++) small_write(p, 1'b0);
      checks++;
      if (pix2 !== 19'd7 || done_pulses != 0) begin
        fails++;
        $display("FAIL frame_pre: pix=%0d pulses=%0d, required 7 0", pix2, done_pulses);
      end
      small_write(7, pass == 1);
      repeat (2) tick();
      checks++;
      if (pix2 !== 19'd0 || done_pulses != (pass == 0 ? 1 : 0)) begin
        fails++;
        $display("FAIL frame_end%0d: pix=%0d pulses=%0d, required 0 %0d",
                 pass, pix2, done_pulses, pass == 0 ? 1 : 0);
      end
    end
    checks++;
    if (err2 !== 1'b0) begin
      fails++;
      $display("FAIL frame_err: coord_err=%b, required 0", err2);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    apply_reset();
    fb_ready = 1'b1;
    post_req(1, 9, 9, 8'h55, 1'b0);
    repeat (2) tick();
    checks++;
    if (req_ack !== 8'h02) begin
      fails++;
      $display("FAIL mid_ack2: req_ack=%b, required 00000010", req_ack);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (req_ack !== '0 || fb_we !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: req_ack=%b fb_we=%b, required 0 0", req_ack, fb_we);
    end
    service_req = '0;
    for (int i = 0; i < N; i++) eng_seen[i] = 1'b0;
    prev_ack = '0;
    prev_we  = 1'b0;
    tick();
    rst  = 1'b0;
    base = writes_cnt;
    post_req(0, 7, 7, 8'h66, 1'b1);
    post_req(2, 8, 8, 8'h77, 1'b1);
    wait_writes(base + 2, 40, "mid");
    checks++;
    if (exp_grant_q.size() != 0 || pixels_done !== 19'd2) begin
      fails++;
      $display("FAIL mid_after: %0d grants left pix=%0d, required 0 2",
               exp_grant_q.size(), pixels_done);
    end
  endtask

  initial begin
    rst         = 1'b1;
    service_req = '0;
    bus         = '0;
    fb_ready    = 1'b1;
    frame_clear = 1'b0;
    sreq2       = '0;
    bus2        = '0;
    ready2      = 1'b1;
    clear2      = 1'b0;
    prev_ack    = '0;
    prev_we     = 1'b0;
    ack_len     = 0;
    we_len      = 0;
    writes_cnt  = 0;
    done_pulses = 0;
    held        = '0;
    for (int i = 0; i < N; i++) begin
      eng_word[i] = '0;
      eng_seen[i] = 1'b0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_coord_err();
    test_frame();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/result_collector.md
# result_collector

Downstream stage of the engine array: arbitrates round-robin among all engines raising `service_req`, runs the `req_ack` handshake with one engine at a time, and samples the shared tri-state 27-bit result bus. It converts each captured {x, y, iterations} word into a frame-buffer write (linear address plus 8-bit data). It also counts written pixels and pulses `frame_done` when a full frame has been stored.

## Interface
- `N_ENGINES`, default 8: number of engines on the bus (2..64).
- `H_RES`, default 640: screen width in pixels.
- `V_RES`, default 480: screen height in pixels.
- `Engine_CLK`  in  1: single clock, rising edge.
- `eRST`  in  1: reset, asynchronous, active-high.
- `service_req`  in  N_ENGINES: bit i high means engine i holds a finished result.
- `result_bus`  in  27: shared engine bus carrying {x[9:0], y[8:0], iter[7:0]}. Valid only while the matching `req_ack` bit is high.
- `req_ack`  out  N_ENGINES: one-hot grant. At most one bit is high.
- `fb_ready`  in  1: frame buffer accepts a write this cycle.
- `fb_we`  out  1: frame-buffer write strobe.
- `fb_addr`  out  19: linear pixel address, y*H_RES + x.
- `fb_data`  out  8: iteration count, low byte.
- `frame_clear`  in  1: synchronous clear of the pixel count and `coord_err`.
- `pixels_done`  out  19: pixels written in the current frame.
- `frame_done`  out  1: one-cycle pulse when the frame completes.
- `coord_err`  out  1: sticky flag; an out-of-range coordinate was received.

## Operation
- Reset values:
  - `req_ack` = 0, `fb_we` = 0, `fb_addr` = 0, `fb_data` = 0.
  - `pixels_done` = 0, `frame_done` = 0, `coord_err` = 0.
  - State = IDLE; round-robin pointer `last` = N_ENGINES-1, so engine 0 has first priority.
- Reset mid-handshake drops `req_ack` and `fb_we` immediately. A result being captured at that moment is discarded.
- Arbitration: search from `last`+1 upward, wrapping modulo N_ENGINES. The first set `service_req` bit wins. `last` updates to the winner on grant.
- State machine:
  - IDLE: if any `service_req` bit is high, set `req_ack[i]` = 1 and go to ACK1. Otherwise stay.
  - ACK1: hold `req_ack[i]`. Go to ACK2. This cycle lets the bus settle and lets the engine see the ack.
  - ACK2: hold `req_ack[i]`. At the exit edge:
    - register `result_bus`;
    - clear `req_ack`;
    - compute `fb_addr` = y*H_RES + x (unsigned, 19 bits) and `fb_data` = iter.
    - If x < H_RES and y < V_RES, set `fb_we` = 1 and go to WRITE.
    - Otherwise set `coord_err` = 1, keep `fb_we` = 0, and go to RELEASE.
  - WRITE: hold `fb_we`, `fb_addr` and `fb_data` stable until a cycle with `fb_ready` = 1. At that edge:
    - clear `fb_we`;
    - increment `pixels_done`;
    - go to RELEASE.
  - RELEASE: wait until `service_req[i]` = 0, then go to IDLE. This guard prevents re-granting a stale request.
- Frame count:
  - When an increment would make `pixels_done` equal to H_RES*V_RES, `pixels_done` wraps to 0 and `frame_done` pulses for one cycle.
  - `frame_clear` zeroes `pixels_done` and `coord_err`. If `frame_clear` coincides with an increment, the clear wins and no `frame_done` pulse occurs.
  - `frame_clear` does not disturb the state machine or a pending write.
- No new grant is issued while in WRITE, so backpressure on `fb_ready` stalls all engines.

## Timing
- `service_req[i]` high in IDLE at edge k:
  - `req_ack[i]` is high for cycles k+1 and k+2 (exactly two cycles).
  - `result_bus` is sampled at edge k+3.
  - `fb_we` is high from k+3.
- With `fb_ready` held high, `fb_we` is high for exactly one cycle (k+3 to k+4) and `pixels_done` updates at edge k+4.
- Engine side: the engine sees `req_ack` at k+2 and drops `service_req` at k+3; `req_ack` falls at k+3. RELEASE at k+4 therefore sees `service_req[i]` = 0 and returns to IDLE at k+5.
- Best-case throughput is one pixel per 5 cycles.
- Two engines requesting in the same cycle are served back-to-back in round-robin order, with no starvation.

## Test plan
- Reset, then engine 0 requests with bus {x=3, y=2, iter=0x2A} and `fb_ready`=1:
  - `req_ack` = 0x01 for exactly 2 cycles;
  - `fb_we` is a 1-cycle pulse with `fb_addr` = 1283 and `fb_data` = 0x2A;
  - `pixels_done` = 1.
- Engines 0, 3 and 5 request simultaneously after reset, and each drops its request once served:
  - grants go 0, 3, 5, in that order, one-hot, with no overlap;
  - three writes occur.
- `fb_ready` held low for 10 cycles during WRITE:
  - `fb_we`, `fb_addr` and `fb_data` stay stable;
  - `req_ack` stays 0 despite other pending requests;
  - the write completes on the first cycle `fb_ready` = 1.
- Result with x=700, y=10:
  - no `fb_we`;
  - `coord_err` = 1 and stays set;
  - `pixels_done` unchanged;
  - engine still released.
- H_RES=4, V_RES=2, 8 valid writes:
  - `frame_done` pulses once on the 8th write;
  - `pixels_done` returns to 0.
  - Repeat with `frame_clear` asserted on the 8th write: `pixels_done` = 0 and no pulse.
- Assert `eRST` while in ACK2: `req_ack` = 0 and `fb_we` = 0 immediately; after release, the next grant goes to engine 0 first.
